// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - Bin computed LSB first through one full-subtractor
// cell and a borrow flip-flop, with a start/done handshake toward a controlling FSM.
module serial_subtractor #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] diff,
   output logic             Bout,
   output logic             ovf
);

   localparam int cnt_w = $clog2(width);
   localparam logic [cnt_w-1:0] last_bit = cnt_w'(width - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [width-1:0] a_sh;
   logic [width-1:0] b_sh;
   logic [width-1:0] r_sh;
   logic [cnt_w-1:0] cnt;
   logic             br;

   logic             ai;
   logic             bi;
   logic             di;
   logic             br_next;
   logic [width-1:0] r_next;

   // Full-subtractor cell on the current LSBs and the stored borrow.
   always_comb begin
      ai      = a_sh[0];
      bi      = b_sh[0];
      di      = ai ^ bi ^ br;
      br_next = (~ai & bi) | (~(ai ^ bi) & br);
      r_next  = {di, r_sh[width-1:1]};
   end

   // NOTE: every register here is state updated on the clock edge, so all use
   // non-blocking assignments; blocking ones would let later statements see new values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         Bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= Bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_next;
               br   <= br_next;
               cnt  <= cnt + 1'b1;
               // Outputs update only on the final bit, so partial results stay hidden.
               if (cnt == last_bit) begin
                  diff  <= r_next;
                  Bout  <= br_next;
                  ovf   <= br ^ br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (width 4) plus a width-8 model-checked sweep.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       bin4;
   logic       busy4;
   logic       done4;
   logic [3:0] diff4;
   logic       bout4;
   logic       ovf4;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       bin8;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       bout8;
   logic       ovf8;

   int         n_cmp;
   int         n_err;
   logic [3:0] prev4;
   logic [7:0] prev8;

   serial_subtractor #(.width(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .Bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .Bout(bout4), .ovf(ovf4)
   );

   serial_subtractor #(.width(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .Bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .Bout(bout8), .ovf(ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One width-4 operation; disturb scrambles operands after acceptance and
   // pulses start during SHIFT, neither of which may affect the result.
   task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic bi, input logic [3:0] ed, input logic eb,
                         input logic eo, input bit disturb);
      int lat;
      bit seen;
      a4     = av;
      b4     = bv;
      bin4   = bi;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      check({tag, "_busy"}, 32'(busy4), 1);
      check({tag, "_hold"}, 32'(diff4), 32'(prev4));
      if (disturb) begin
         a4   = ~av;
         b4   = bv + 4'd1;
         bin4 = ~bi;
      end
      lat  = 0;
      seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         if (disturb && i == 2) begin
            start4 = 1'b1;
            a4     = 4'hF;
            b4     = 4'h0;
         end
         if (disturb && i == 3) start4 = 1'b0;
         tick();
         if (done4) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_nobusy"}, 32'(busy4), 0);
      check({tag, "_diff"}, 32'(diff4), 32'(ed));
      check({tag, "_bout"}, 32'(bout4), 32'(eb));
      check({tag, "_ovf"}, 32'(ovf4), 32'(eo));
      prev4 = ed;
      tick();
      check({tag, "_strobe"}, 32'(done4), 0);
      check({tag, "_idle"}, 32'(busy4), 0);
   endtask

   initial begin
      int last_done;
      int n_done;
      int lat;
      logic [31:0] full;
      int sa;
      int sb;
      int s;
      logic [7:0] exp_d;
      logic exp_b;
      logic exp_o;

      n_cmp  = 0;
      n_err  = 0;
      prev4  = 4'h0;
      prev8  = 8'h0;
      rst_n  = 1'b0;
      start4 = 1'b1;  // reset must win over start
      a4     = 4'h5;
      b4     = 4'h1;
      bin4   = 1'b0;
      start8 = 1'b0;
      a8     = 8'h0;
      b8     = 8'h0;
      bin8   = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(busy4), 0);
      check("rst_done", 32'(done4), 0);
      check("rst_diff", 32'(diff4), 0);
      check("rst_bout", 32'(bout4), 0);
      check("rst_ovf", 32'(ovf4), 0);
      start4 = 1'b0;
      rst_n  = 1'b1;
      tick();
      check("rst_nostart", 32'(busy4), 0);

      run_op("basic",  4'b0101, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
      run_op("under0", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
      run_op("eqbin",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
      run_op("ovfneg", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);
      run_op("ovfpos", 4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0);
      run_op("ignore", 4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);

      // start held high: accepts every width+2 = 6 cycles.
      a4        = 4'b0011;
      b4        = 4'b0010;
      bin4      = 1'b0;
      start4    = 1'b1;
      last_done = -1;
      n_done    = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done4) begin
            check("held_diff", 32'(diff4), 1);
            if (last_done >= 0) check("held_period", i - last_done, 6);
            check("held_excl", 32'(busy4), 0);
            last_done = i;
            n_done++;
         end
      end
      check("held_count", n_done, 3);
      start4 = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("held_drained", 32'(busy4), 0);

      // Reset at the 2nd SHIFT edge aborts the operation.
      a4     = 4'b1010;
      b4     = 4'b0011;
      bin4   = 1'b0;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", 32'(busy4), 0);
      check("abort_done", 32'(done4), 0);
      check("abort_diff", 32'(diff4), 0);
      check("abort_bout", 32'(bout4), 0);
      prev4  = 4'h0;
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done4) n_done++;
      end
      check("abort_nodone", n_done, 0);
      run_op("fresh", 4'b1010, 4'b0011, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);

      // Width 8 against an integer model.
      prev8 = 8'h0;
      for (int op = 0; op < 500; op++) begin
         a8   = 8'($urandom_range(255));
         b8   = 8'($urandom_range(255));
         bin8 = 1'($urandom_range(1));
         full = 32'(int'(a8) - int'(b8) - int'(bin8));
         exp_d = full[7:0];
         exp_b = (int'(a8) < int'(b8) + int'(bin8));
         sa = int'($signed(a8));
         sb = int'($signed(b8));
         s  = sa - sb - int'(bin8);
         exp_o = (s < -128) || (s > 127);
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
         a8 = ~a8;
         b8 = ~b8;
         check("rnd_hold", 32'(diff8), 32'(prev8));
         lat = 0;
         for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick();
            if (done8) lat = i;
         end
         check("rnd_latency", lat, 8);
         check("rnd_diff", 32'(diff8), 32'(exp_d));
         check("rnd_bout", 32'(bout8), 32'(exp_b));
         check("rnd_ovf", 32'(ovf8), 32'(exp_o));
         prev8 = exp_d;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor: computes a − b − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic companion of the team's combinational ripple adder, `fullAdder4`, and shares its operand/carry naming and width parameterisation. It sits on area-constrained datapaths where a few cycles of latency are acceptable, with a start/done handshake toward the controlling FSM.

## Interface
- width, default 4, operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk.
- start  input  1  request pulse/level; accepted only in IDLE.
- a  input  width  minuend; sampled at the accepting edge only.
- b  input  width  subtrahend; sampled at the accepting edge only.
- Bin  input  1  borrow-in; sampled at the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion strobe, high in DONE.
- diff  output  width  result a − b − Bin mod 2^width.
- Bout  output  1  unsigned borrow-out, i.e. a < b + Bin.
- ovf  output  1  two's-complement overflow of the signed subtraction.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, latch a, b and Bin into internal shift registers and the borrow FF.
  - Clear the bit counter to 0 and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per edge:
  - Operand bits: ai = a_sh[0], bi = b_sh[0].
  - Result bit: di = ai ^ bi ^ br.
  - Borrow update: br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - Shift di into the MSB of the result shift register; shift a_sh and b_sh right by 1.
  - Increment the counter.
  - When the counter = width−1, the same edge moves to DONE and updates the outputs:
    - diff ← final result register.
    - Bout ← br_next.
    - ovf ← (borrow into MSB) ^ br_next.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE (SHIFT or DONE) is ignored; no queuing.
- start held high continuously: a new operation is accepted in the IDLE cycle following DONE, so back-to-back throughput is one result per width+2 cycles.
- a, b and Bin may change freely after the accepting edge without affecting the result.
- diff, Bout and ovf hold their last completed values through later IDLE and SHIFT cycles. They change only at the edge entering DONE, so partial results are never visible.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, counter=0, borrow FF=0.
  - busy=0, done=0, diff=0, Bout=0, ovf=0.
  - Internal shift registers cleared.
- Reset during SHIFT or DONE aborts the operation. The next cycle shows IDLE with all outputs 0; done is never asserted for the aborted operation.
- rst_n=0 has priority over start at the same edge.
- Latency, with edge E0 accepting start:
  - busy=1 from E0 until E_width.
  - done=1 and the new diff/Bout/ovf valid from E_width to E_width+1.
  - IDLE again after E_width+1.
- busy and done are never high simultaneously. Both are registered outputs; none is combinational from inputs.
- Boundary wrap: diff is always mod 2^width.
  - 0 − 1 yields all-ones with Bout=1.
  - a = b with Bin=1 yields all-ones with Bout=1.

## Test plan
- Basic: width=4, a=0101, b=0001, Bin=0, start pulse → busy for 4 cycles; done 4 cycles after the start edge; diff=0100, Bout=0, ovf=0.
- Underflow: a=0000, b=0001, Bin=0 → diff=1111, Bout=1, ovf=0. Then a=1111, b=1111, Bin=1 → diff=1111, Bout=1, ovf=0.
- Signed overflow: a=1000, b=0001, Bin=0 → diff=0111, Bout=0, ovf=1. Then a=0111, b=1111, Bin=0 → diff=1000, Bout=1, ovf=1.
- Handshake:
  - Pulse start again during SHIFT with different operands → ignored; the first result is unchanged.
  - Hold start high for 20 cycles with a=0011, b=0010 → done every 6 cycles, diff=0001 each time.
  - Change a/b right after the accepting edge → result unaffected.
- Reset mid-operation: start a=1010, b=0011, then drive rst_n=0 at the 2nd SHIFT edge → next cycle IDLE, busy=0, done=0, diff=0000. No done strobe follows; a fresh start then yields diff=0111, Bout=0.
- Randomised width=8: 500 operations checked against a − b − Bin, with signed overflow computed by a model and diff held stable between done strobes.
